sdram_wbuf: RTL

Write-posting buffer between the 68000-side bus logic and one toggle-handshake port of the `sdram` controller. CPU writes are acknowledged as soon as they enter a small FIFO and are drained to SDRAM in the background. CPU reads wait for the FIFO to empty, then pass through, so program order is strictly preserved. The block occupies one `reqN/ackN` port pair; the other controller ports are untouched.

---
 rtl/sdram_wbuf.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sdram_wbuf.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_wbuf
//  Purpose  : Write-posting FIFO in front of one toggle-handshake SDRAM port.
//             Writes are acked on entry; reads wait for the FIFO to drain.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [24:1]              cpu_addr,
    input  logic [15:0]              cpu_din,
    input  logic                     cpu_wrl,
    input  logic                     cpu_wrh,
    input  logic                     cpu_req,
    output logic                     cpu_ack,
    output logic [15:0]              cpu_dout,
    output logic [24:1]              ram_addr,
    output logic [15:0]              ram_din,
    output logic                     ram_wrl,
    output logic                     ram_wrh,
    output logic                     ram_req,
    input  logic                     ram_ack,
    input  logic [15:0]              ram_dout,
    output logic [$clog2(DEPTH):0]   wb_level
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_WAIT = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;

    logic [24:1]    r_mem_addr [DEPTH];
    logic [15:0]    r_mem_data [DEPTH];
    logic           r_mem_wrl  [DEPTH];
    logic           r_mem_wrh  [DEPTH];

    logic [c_AW:0]  r_wr_ptr;
    logic [c_AW:0]  r_rd_ptr;
    logic [1:0]     r_state;
    logic           r_rd_busy;
    logic           r_cpu_ack;
    logic [15:0]    r_cpu_dout;
    logic [24:1]    r_ram_addr;
    logic [15:0]    r_ram_din;
    logic           r_ram_wrl;
    logic           r_ram_wrh;
    logic           r_ram_req;

    logic           w_empty;
    logic           w_full;
    logic           w_pend;
    logic           w_is_rd;
    logic           w_push;
    logic           w_pop;
    logic           w_rd_issue;
    logic           w_rd_done;
    logic [c_AW-1:0] w_wr_idx;
    logic [c_AW-1:0] w_rd_idx;

    assign w_wr_idx   = r_wr_ptr[c_AW-1:0];
    assign w_rd_idx   = r_rd_ptr[c_AW-1:0];
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    // Full is derived from registered pointers only: a slot freed by a pop
    // becomes usable one cycle later.
    assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) && (w_wr_idx == w_rd_idx);
    assign w_pend     = (cpu_req != r_cpu_ack) && !r_rd_busy;
    assign w_is_rd    = !cpu_wrl && !cpu_wrh;
    assign w_push     = w_pend && !w_is_rd && !w_full;
    assign w_pop      = (r_state == S_WR_WAIT) && (ram_ack == r_ram_req);
    assign w_rd_issue = (r_state == S_IDLE) && w_empty && w_pend && w_is_rd;
    assign w_rd_done  = (r_state == S_RD_WAIT) && (ram_ack == r_ram_req);

    // Storage needs no reset; the pointers alone define valid entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[w_wr_idx] <= cpu_addr;
            r_mem_data[w_wr_idx] <= cpu_din;
            r_mem_wrl[w_wr_idx]  <= cpu_wrl;
            r_mem_wrh[w_wr_idx]  <= cpu_wrh;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_state    <= S_IDLE;
            r_rd_busy  <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_cpu_dout <= '0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_wrl  <= 1'b0;
            r_ram_wrh  <= 1'b0;
            r_ram_req  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push || w_rd_done) begin
                r_cpu_ack <= ~r_cpu_ack;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_ram_addr <= r_mem_addr[w_rd_idx];
                        r_ram_din  <= r_mem_data[w_rd_idx];
                        r_ram_wrl  <= r_mem_wrl[w_rd_idx];
                        r_ram_wrh  <= r_mem_wrh[w_rd_idx];
                        r_ram_req  <= ~r_ram_req;
                        r_state    <= S_WR_WAIT;
                    end else if (w_rd_issue) begin
                        r_ram_addr <= cpu_addr;
                        r_ram_wrl  <= 1'b0;
                        r_ram_wrh  <= 1'b0;
                        r_ram_req  <= ~r_ram_req;
                        r_rd_busy  <= 1'b1;
                        r_state    <= S_RD_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (w_pop) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD_WAIT: begin
                    if (w_rd_done) begin
                        r_cpu_dout <= ram_dout;
                        r_rd_busy  <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_ack  = r_cpu_ack;
    assign cpu_dout = r_cpu_dout;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign ram_wrl  = r_ram_wrl;
    assign ram_wrh  = r_ram_wrh;
    assign ram_req  = r_ram_req;
    assign wb_level = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire
